// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg
//   Shared definitions for the register-file writeback arbiter:
//   default data/index widths, the SP register index, and the
//   grant_id encoding reported on the arbiter's grant_id output.
package regfile_wb_arbiter_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 2;

    // The stack pointer lives in R3.
    localparam logic [1:0] SP_IDX = 2'd3;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_SP   = 2'd1,
        GNT_LD   = 2'd2,
        GNT_ALU  = 2'd3
    } grant_t;

endpackage

// File: rtl/regfile_wb_arbiter_age.sv
// wb_age_counter
//   Saturating count of consecutive cycles a writeback requester has been
//   pending without being accepted. starve goes high once the count
//   reaches STARVE_LIMIT, promoting the requester above fixed priority.
//
//   clk     in   clock
//   rst     in   asynchronous active-low reset (count -> 0)
//   inc     in   requester pending and not accepted this cycle
//   clr     in   requester accepted or not requesting this cycle
//   starve  out  count >= STARVE_LIMIT
module wb_age_counter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned AGE_W        = 3,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic starve
);

    logic [AGE_W-1:0] age;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age <= '0;
        end else if (clr) begin
            age <= '0;
        end else if (inc && (age != '1)) begin
            age <= age + AGE_W'(1);
        end
    end

    assign starve = (age >= AGE_W'(STARVE_LIMIT));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port among the SP update unit,
//   the load unit and the ALU. Fixed priority SP > LOAD > ALU, overridden
//   by per-requester aging so LOAD and ALU cannot starve. The winner is
//   registered and drives the register file write port directly, so a
//   write is performed one edge after the grant edge.
//
//   Optional feature: define WB_FORWARD_EN to add fwd_valid/fwd_rd/fwd_data,
//   a copy of the in-flight write for decode-stage bypassing.
//
//   clk, rst                 clock, asynchronous active-low reset
//   sp_req/sp_data/sp_ack    SP writeback (destination always R3)
//   ld_req/ld_rd/ld_data/ld_ack      load writeback
//   alu_req/alu_rd/alu_data/alu_ack  ALU writeback
//   wenabel/rd/write_data    registered register-file write port
//   grant_id                 registered source of the current write (0 none)
//   fwd_valid/fwd_rd/fwd_data (WB_FORWARD_EN only) in-flight write
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned AGE_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sp_req,
    input  logic [DATA_W-1:0] sp_data,
    output logic              sp_ack,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ack,
    input  logic              alu_req,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ack,
    output logic              wenabel,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] write_data,
    output logic [1:0]        grant_id
`ifdef WB_FORWARD_EN
    ,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    if (((2 ** AGE_W) - 1) < STARVE_LIMIT) begin : g_age_check
        $error("AGE_W too narrow to reach STARVE_LIMIT");
    end

    grant_t sel;
    logic   ld_starve;
    logic   alu_starve;

    // Aged requesters are checked before SP; acks are held low in reset.
    always_comb begin
        sel = GNT_NONE;
        if (!rst) begin
            sel = GNT_NONE;
        end else if (ld_starve && ld_req) begin
            sel = GNT_LD;
        end else if (alu_starve && alu_req) begin
            sel = GNT_ALU;
        end else if (sp_req) begin
            sel = GNT_SP;
        end else if (ld_req) begin
            sel = GNT_LD;
        end else if (alu_req) begin
            sel = GNT_ALU;
        end
    end

    assign sp_ack  = (sel == GNT_SP);
    assign ld_ack  = (sel == GNT_LD);
    assign alu_ack = (sel == GNT_ALU);

    wb_age_counter #(
        .AGE_W        (AGE_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_ld_age (
        .clk    (clk),
        .rst    (rst),
        .inc    (ld_req && !ld_ack),
        .clr    (!ld_req || ld_ack),
        .starve (ld_starve)
    );

    wb_age_counter #(
        .AGE_W        (AGE_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_alu_age (
        .clk    (clk),
        .rst    (rst),
        .inc    (alu_req && !alu_ack),
        .clr    (!alu_req || alu_ack),
        .starve (alu_starve)
    );

    // rd/write_data hold their last value when nothing is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wenabel    <= 1'b0;
            rd         <= '0;
            write_data <= '0;
            grant_id   <= GNT_NONE;
        end else begin
            wenabel  <= (sel != GNT_NONE);
            grant_id <= sel;
            case (sel)
                GNT_SP: begin
                    rd         <= ADDR_W'(SP_IDX);
                    write_data <= sp_data;
                end
                GNT_LD: begin
                    rd         <= ld_rd;
                    write_data <= ld_data;
                end
                GNT_ALU: begin
                    rd         <= alu_rd;
                    write_data <= alu_data;
                end
                default: ;
            endcase
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_valid = wenabel;
    assign fwd_rd    = rd;
    assign fwd_data  = write_data;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (wenabel/rd/write_data) among three writeback requesters:
  - SP update unit (push/pop/call/ret)
  - load unit (memory data)
  - ALU result
- Fixed priority SP > LOAD > ALU, with an aging override so LOAD and ALU cannot starve.
- Output is registered and drives the register file write port directly; sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 8, register data width
- ADDR_W, 2, register index width (4 registers; R3 = SP)
- STARVE_LIMIT, 4, consecutive lost cycles after which a LOAD/ALU requester is promoted
- AGE_W, 3, age counter width; must satisfy 2^AGE_W-1 >= STARVE_LIMIT

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- sp_req  in  1  SP requester has a pending write
- sp_data  in  DATA_W  new SP value (destination always R3)
- sp_ack  out  1  SP request accepted this cycle
- ld_req  in  1  load writeback pending
- ld_rd  in  ADDR_W  load destination
- ld_data  in  DATA_W  load data
- ld_ack  out  1  load request accepted this cycle
- alu_req  in  1  ALU writeback pending
- alu_rd  in  ADDR_W  ALU destination
- alu_data  in  DATA_W  ALU result
- alu_ack  out  1  ALU request accepted this cycle
- wenabel  out  1  register file write enable (registered)
- rd  out  ADDR_W  register file write index (registered)
- write_data  out  DATA_W  register file write data (registered)
- grant_id  out  2  last granted source, registered: 0 none, 1 SP, 2 LOAD, 3 ALU

Behaviour:
- Reset (rst=0, asynchronous):
  - wenabel=0, rd=0, write_data=0, grant_id=0; both age counters=0.
  - Acks forced 0 while rst=0.
  - A write registered but not yet performed is dropped.
- Handshake:
  - Requester holds req and payload stable until ack.
  - ack is combinational, same cycle as req; the transfer completes on that rising edge.
  - Exactly one ack at most per cycle.
  - req deasserted without ack: request withdrawn, no write.
- Arbitration, evaluated each cycle, first match wins:
  - (1) ld_age >= STARVE_LIMIT and ld_req
  - (2) alu_age >= STARVE_LIMIT and alu_req
  - (3) sp_req
  - (4) ld_req
  - (5) alu_req
  - (6) none
- Age counters (ld_age, alu_age):
  - +1 on each cycle the requester is pending and not acked; saturate at 2^AGE_W-1.
  - Clear on ack or when req is low.
- Output register:
  - Winner at cycle N loads rd/write_data, sets wenabel=1 and grant_id at edge N.
  - The register file writes at edge N+1.
  - Request-to-register-update latency = 2 edges.
  - No winner: wenabel=0; rd/write_data hold their previous values; grant_id=0.
- SP grant: rd=3 and write_data=sp_data, regardless of other inputs.
- Same destination from multiple requesters in one cycle: only the winner writes; losers wait and write on later cycles in arbitration order. No merging.
- Back-to-back grants allowed every cycle; sustained throughput is 1 write/cycle.
- LOAD or ALU targeting R3 is legal and arbitrated normally.

Optional Feature:
- WB_FORWARD_EN
- Defined: adds outputs fwd_valid (1), fwd_rd (ADDR_W), fwd_data (DATA_W).
  - These equal the registered wenabel/rd/write_data, i.e. the write in flight during cycle N+1.
  - Decode uses them to bypass register file reads of a register being written.
  - fwd_valid=0 in reset.
- Undefined: ports absent; no other behaviour change.

Decomposition:
- Shared package holds:
  - DATA_W/ADDR_W defaults
  - SP_IDX=2'd3
  - grant_id encodings GNT_NONE/GNT_SP/GNT_LD/GNT_ALU
- One sub-module, wb_age_counter: saturating age counter with inc/clr inputs and a starve output comparing against STARVE_LIMIT. Instantiated twice (LOAD, ALU).
- Priority select and output register stay in the top module.

Test Plan:
- Reset, all req=0 → wenabel=0, rd=0, write_data=0, grant_id=0, no acks.
- Reset values checked while rst=0; rst driven mid-grant clears wenabel immediately.
- alu_req=1, alu_rd=1, alu_data=0x3C alone:
  - alu_ack=1 same cycle.
  - Next cycle wenabel=1, rd=1, write_data=0x3C, grant_id=3.
  - Register file R1 reads 0x3C after the following edge.
- sp_req (0xFE), ld_req (rd=2, 0x11) and alu_req (rd=0, 0x22) together:
  - Grants in order SP, LOAD, ALU on consecutive cycles.
  - Writes R3=0xFE, R2=0x11, R0=0x22; wenabel high 3 consecutive cycles.
- sp_req held high continuously with alu_req pending:
  - ALU acked after exactly STARVE_LIMIT=4 lost cycles (on the 5th cycle); SP resumes after.
- ld_req and alu_req both targeting R1 (0xAA, 0xBB) → R1 ends 0xBB; LOAD written first.
- With WB_FORWARD_EN defined: during the cycle after an alu_ack for rd=2, data 0x5A → fwd_valid=1, fwd_rd=2, fwd_data=0x5A.
